uart_rx_ctrl: RTL and testbench
===============================

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clk cycles per UART bit (50 MHz / 115200); legal range 4..1023.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 rx_in  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-005 rx_en  output  1  high while a frame is in progress, from confirmed start bit to end of stop-bit sample.
REQ-006 bit_cnto  output  10  bit index of current frame: 0 = start, 1..8 = data bit 0..7, 9 = stop.
REQ-007 sample_stb  output  1  one-cycle pulse at each mid-bit sample point.
REQ-008 rx_data  output  8  last correctly framed byte.
REQ-009 rx_valid  output  1  one-cycle pulse: rx_data has just been updated.
REQ-010 frame_err  output  1  one-cycle pulse: stop bit sampled low.

Function
REQ-011 rx_in SHALL pass a 2-flop synchronizer (preset to 1) before use; rx_s denotes the synchronized value, prev_s its one-cycle delayed copy.
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP; a baud counter (10 bit) counts clk cycles within a bit.
REQ-013 IDLE: on prev_s=1 and rx_s=0, go START, baud counter=0, bit_cnto=0; a line held low never triggers (edge required).
REQ-014 START: at baud counter = CLKS_PER_BIT/2 - 1 (integer division), pulse sample_stb; if rx_s=0 go DATA, counter=0, bit_cnto=1, rx_en=1; if rx_s=1 return to IDLE (glitch rejected), no other output changes.
REQ-015 DATA: at counter = CLKS_PER_BIT - 1, pulse sample_stb, shift rx_s into an internal 8-bit shift register from the MSB end (LSB-first reception), counter=0, bit_cnto increments; after the sample taken with bit_cnto=8, go STOP with bit_cnto=9.
REQ-016 STOP: at counter = CLKS_PER_BIT - 1, pulse sample_stb; rx_s=1 -> rx_data = shift register, rx_valid=1 for one cycle; rx_s=0 -> frame_err=1 for one cycle, rx_data unchanged; in both cases go IDLE, rx_en=0, bit_cnto=0 on the following edge.
REQ-017 rx_valid, frame_err, and the return to IDLE SHALL be registered in the same cycle; a new falling edge is accepted from the next cycle in IDLE.
REQ-018 bit_cnto SHALL hold its value between sample points and never exceed 9; bits 9:4 are always 0.
REQ-019 Latency: rx_valid asserts 2 (sync) + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 clk cycles (+/-1) after the rx_in falling edge.
REQ-020 rx_in changes during a non-sample cycle SHALL not affect state.

Reset
REQ-021 On rst=1 at a clock edge: state=IDLE, counter=0, bit_cnto=0, rx_en=0, sample_stb=0, rx_valid=0, frame_err=0, rx_data=8'h00, shift register=0, synchronizer flops=1.
REQ-022 rst mid-frame SHALL abort the frame with no rx_valid or frame_err pulse; reception restarts only on a fresh falling edge after rst deasserts.
REQ-023 rst has priority over every other event in the same cycle.

Verification (CLKS_PER_BIT=16)
REQ-024 Frame 0x55 (start 0, bits 1,0,1,0,1,0,1,0, stop 1) -> one rx_valid pulse, rx_data=8'h55, frame_err never high, bit_cnto steps 0,1..9,0.
REQ-025 Back-to-back frames 0xA5 then 0x3C with no idle gap -> two rx_valid pulses, rx_data 8'hA5 then 8'h3C.
REQ-026 Frame 0xFF with stop bit driven 0 -> frame_err one-cycle pulse, no rx_valid, rx_data keeps previous value; line held low afterwards -> no new frame until line goes high then low.
REQ-027 rx_in low for 4 cycles then high -> START aborts at its sample point, rx_en stays 0, no output pulse.
REQ-028 rst asserted for one cycle while bit_cnto=5 -> all outputs at reset values next cycle; next valid frame 0x81 received correctly.
REQ-029 Sample check: count sample_stb pulses per good frame = 10, each within the middle cycle of its bit (+/-1 cycle).

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// 8N1 UART receiver: 2-flop synchronizer, falling-edge start detection,
// mid-bit sampling and registered frame status pulses.
module uart_rx_ctrl #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    output logic       rx_en,
    output logic [9:0] bit_cnto,
    output logic       sample_stb,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err
);

    localparam logic [9:0] HALF_M1 = 10'(CLKS_PER_BIT / 2 - 1);
    localparam logic [9:0] FULL_M1 = 10'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state_q, state_d;
    logic [9:0]  cnt_q, cnt_d;
    logic [3:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        en_q, en_d;
    logic        stb_q, stb_d;
    logic        vld_q, vld_d;
    logic        ferr_q, ferr_d;
    logic [1:0]  sync_q;
    logic        prev_q;
    logic        rx_s;

    assign rx_s = sync_q[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            en_q    <= 1'b0;
            stb_q   <= 1'b0;
            vld_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rx_in};
            prev_q  <= rx_s;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            en_q    <= en_d;
            stb_q   <= stb_d;
            vld_q   <= vld_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        en_d    = en_q;
        stb_d   = 1'b0;
        vld_d   = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                en_d  = 1'b0;
                // Edge required: a line stuck low must not retrigger.
                if (prev_q && !rx_s) state_d = START;
            end
            START: begin
                if (cnt_q == HALF_M1) begin
                    stb_d = 1'b1;
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d = DATA;
                        bit_d   = 4'd1;
                        en_d    = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            DATA: begin
                if (cnt_q == FULL_M1) begin
                    stb_d   = 1'b1;
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 4'd1;
                    if (bit_q == 4'd8) state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            STOP: begin
                if (cnt_q == FULL_M1) begin
                    stb_d   = 1'b1;
                    cnt_d   = '0;
                    bit_d   = '0;
                    en_d    = 1'b0;
                    state_d = IDLE;
                    if (rx_s) begin
                        data_d = shift_q;
                        vld_d  = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rx_en      = en_q;
    assign bit_cnto   = {6'd0, bit_q};
    assign sample_stb = stb_q;
    assign rx_data    = data_q;
    assign rx_valid   = vld_q;
    assign frame_err  = ferr_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl at CLKS_PER_BIT=16: the driver queues the
// expected frame result, a negedge monitor checks every sample and frame event.
module tb_uart_rx_ctrl;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_in = 1'b1;
    logic       rx_en;
    logic [9:0] bit_cnto;
    logic       sample_stb;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;

    uart_rx_ctrl #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rx_in),
        .rx_en      (rx_en),
        .bit_cnto   (bit_cnto),
        .sample_stb (sample_stb),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   frm_start = 0;
    int   stb_idx   = 0;
    int   off;
    exp_t e;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        frm_start = cyc;
        for (int i = 0; i < 10; i++) begin
            rx_in = bits[i];
            tick(CPB);
        end
    endtask

    task automatic push(input bit is_err, input logic [7:0] d);
        exp_t x;
        x.is_err = is_err;
        x.data   = d;
        sb.push_back(x);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rx_en"}, 32'(rx_en), 0);
        chk({tag, "_bit_cnto"}, 32'(bit_cnto), 0);
        chk({tag, "_sample_stb"}, 32'(sample_stb), 0);
        chk({tag, "_rx_valid"}, 32'(rx_valid), 0);
        chk({tag, "_frame_err"}, 32'(frame_err), 0);
        chk({tag, "_rx_data"}, 32'(rx_data), 0);
    endtask

    // Mid-bit for bit k is edge + 2 sync cycles + CPB/2 + k*CPB, +/-1.
    always @(negedge clk) begin
        if (rst) begin
            stb_idx = 0;
        end else begin
            if (sample_stb && (rx_en || rx_valid || frame_err)) begin
                off = cyc - frm_start - 2 - CPB / 2 - CPB * stb_idx;
                chk("stb_midbit", 32'(off >= -1 && off <= 1), 1);
                chk("bit_cnto_step", 32'(bit_cnto), (stb_idx == 9) ? 0 : 32'(stb_idx + 1));
                stb_idx++;
            end
            if (rx_valid || frame_err) begin
                chk("stb_count", 32'(stb_idx), 10);
                stb_idx = 0;
                off = cyc - frm_start - (2 + CPB / 2 + 9 * CPB + 1);
                chk("latency", 32'(off >= -1 && off <= 1), 1);
                chk("valid_err_excl", 32'(rx_valid && frame_err), 0);
                if (sb.size() == 0) begin
                    chk("unexpected_event", 32'(rx_valid), 32'(frame_err));
                    chk("unexpected_event_any", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("event_kind_err", 32'(frame_err), 32'(e.is_err));
                    chk("rx_data", 32'(rx_data), 32'(e.data));
                end
            end
        end
    end

    initial begin
        logic seen;
        logic found;

        tick(3);
        chk_reset_outputs("reset");
        rst = 1'b0;
        tick(20);

        push(1'b0, 8'h55);
        send_frame(8'h55, 1'b1);
        tick(10);

        push(1'b0, 8'hA5);
        push(1'b0, 8'h3C);
        send_frame(8'hA5, 1'b1);
        send_frame(8'h3C, 1'b1);
        tick(10);

        // Bad stop bit, then the line stays low: no new frame may start.
        push(1'b1, 8'h3C);
        send_frame(8'hFF, 1'b0);
        tick(48);
        chk("held_low_rx_en", 32'(rx_en), 0);
        chk("held_low_bit_cnto", 32'(bit_cnto), 0);
        rx_in = 1'b1;
        tick(20);

        rx_in = 1'b0;
        tick(4);
        rx_in = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            seen = seen | rx_en;
        end
        chk("glitch_rx_en", 32'(seen), 0);
        tick(10);

        // Abort a frame with reset once bit_cnto reaches 5.
        rx_in = 1'b0;
        frm_start = cyc;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick(1);
            if (bit_cnto == 10'd5) found = 1'b1;
        end
        chk("reach_bit5", 32'(found), 1);
        rx_in = 1'b1;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk_reset_outputs("midframe_rst");
        tick(20);

        push(1'b0, 8'h81);
        send_frame(8'h81, 1'b1);
        tick(20);

        for (int i = 0; i < 500 && sb.size() > 0; i++) tick(1);
        chk("scoreboard_empty", 32'(sb.size()), 0);
        chk("final_rx_data", 32'(rx_data), 32'h81);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
